// File: rtl/zymouse_axil_pkg.sv
// zymouse_axil_pkg: response codes, channel FSM states and address decode helper
package zymouse_axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction
endpackage

// File: rtl/zymouse_axil_wr_ctrl.sv
// zymouse_axil_wr_ctrl: independent AW/W capture, single-cycle commit and B response FSM
module zymouse_axil_wr_ctrl
  import zymouse_axil_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 6,
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 2,
  localparam int LSB = addr_lsb(DW),
  localparam int IW = AW - LSB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  output logic            commit,
  output logic [IW-1:0]   idx,
  output logic [DW-1:0]   data,
  output logic [DW/8-1:0] strb
);
  wr_state_e st_q, st_d;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] wdata_q;
  logic [DW/8-1:0] wstrb_q;
  logic [1:0] bresp_q, bresp_d;
  logic aw_hs, w_hs, have_aw, have_w;
  logic unused_lsb;
  assign unused_lsb = ^awaddr[LSB-1:0];
  assign awready = st_q == W_IDLE || st_q == W_HAVE_W;
  assign wready = st_q == W_IDLE || st_q == W_HAVE_AW;
  assign bvalid = st_q == W_RESP;
  assign bresp = bresp_q;
  always_comb begin
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    have_aw = aw_hs || st_q == W_HAVE_AW;
    have_w = w_hs || st_q == W_HAVE_W;
    commit = have_aw && have_w;
    idx = aw_hs ? awaddr[AW-1:LSB] : idx_q;
    data = w_hs ? wdata : wdata_q;
    strb = w_hs ? wstrb : wstrb_q;
    bresp_d = !commit ? bresp_q :
              int'(idx) < NUM_RW ? RESP_OKAY :
              int'(idx) < NUM_RW + NUM_RO ? RESP_SLVERR : RESP_DECERR;
    st_d = st_q == W_RESP ? (bready ? W_IDLE : W_RESP) :
           commit ? W_RESP : have_aw ? W_HAVE_AW : have_w ? W_HAVE_W : W_IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      st_q <= W_IDLE;
      idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      st_q <= st_d;
      idx_q <= idx;
      wdata_q <= data;
      wstrb_q <= strb;
      bresp_q <= bresp_d;
    end
endmodule

// File: rtl/zymouse_axil_regfile.sv
// zymouse_axil_regfile: AXI4-Lite slave with RW control registers, RO status inputs and access pulses
module zymouse_axil_regfile
  import zymouse_axil_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_RW = 4,
  parameter int C_NUM_RO = 2
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                       AWPROT,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [C_DATA_WIDTH-1:0]          WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [C_ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                       ARPROT,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [C_DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RVALID,
  input  logic                             RREADY,
  output logic [C_NUM_RW*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_RO*C_DATA_WIDTH-1:0] ro_in,
  output logic [C_NUM_RW-1:0]              wr_pulse,
  output logic [C_NUM_RW+C_NUM_RO-1:0]     rd_pulse
);
  localparam int DW = C_DATA_WIDTH;
  localparam int LSB = addr_lsb(DW);
  localparam int IW = C_ADDR_WIDTH - LSB;
  logic [DW-1:0] regs_q [C_NUM_RW];
  logic [DW-1:0] regs_d [C_NUM_RW];
  logic [C_NUM_RW-1:0] wr_pulse_q, wr_pulse_d;
  logic commit;
  logic [IW-1:0] idx, ar_idx;
  logic [DW-1:0] data, rdata_q, rdata_d;
  logic [DW/8-1:0] strb;
  logic [1:0] rresp_q, rresp_d;
  logic ar_hs;
  rd_state_e r_st_q, r_st_d;
  logic unused_in;
  assign unused_in = ^{AWPROT, ARPROT, ARADDR[LSB-1:0]};
  zymouse_axil_wr_ctrl #(
    .DW(DW), .AW(C_ADDR_WIDTH), .NUM_RW(C_NUM_RW), .NUM_RO(C_NUM_RO)
  ) u_wr (
    .clk(ACLK), .rst_n(ARESETN),
    .awaddr(AWADDR), .awvalid(AWVALID), .awready(AWREADY),
    .wdata(WDATA), .wstrb(WSTRB), .wvalid(WVALID), .wready(WREADY),
    .bresp(BRESP), .bvalid(BVALID), .bready(BREADY),
    .commit(commit), .idx(idx), .data(data), .strb(strb)
  );
  assign wr_pulse = wr_pulse_q;
  assign ARREADY = r_st_q == R_IDLE;
  assign RVALID = r_st_q == R_DATA;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  always_comb begin
    regs_d = regs_q;
    wr_pulse_d = '0;
    reg_out = '0;
    for (int i = 0; i < C_NUM_RW; i++) begin
      reg_out[i*DW +: DW] = regs_q[i];
      if (commit && int'(idx) == i) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < DW/8; b++)
          if (strb[b]) regs_d[i][8*b +: 8] = data[8*b +: 8];
      end
    end
  end
  // Read data is taken from the pre-commit flops, so a same-cycle commit is not visible
  always_comb begin
    ar_hs = ARVALID && ARREADY && ARESETN;
    ar_idx = ARADDR[C_ADDR_WIDTH-1:LSB];
    rdata_d = ar_hs ? '0 : rdata_q;
    rresp_d = ar_hs ? RESP_DECERR : rresp_q;
    rd_pulse = '0;
    for (int i = 0; i < C_NUM_RW; i++)
      if (ar_hs && int'(ar_idx) == i) begin
        rd_pulse[i] = 1'b1;
        rdata_d = regs_q[i];
        rresp_d = RESP_OKAY;
      end
    for (int j = 0; j < C_NUM_RO; j++)
      if (ar_hs && int'(ar_idx) == C_NUM_RW + j) begin
        rd_pulse[C_NUM_RW+j] = 1'b1;
        rdata_d = ro_in[j*DW +: DW];
        rresp_d = RESP_OKAY;
      end
    r_st_d = ar_hs ? R_DATA : (RVALID && RREADY) ? R_IDLE : r_st_q;
  end
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      regs_q <= '{default: '0};
      wr_pulse_q <= '0;
      r_st_q <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      regs_q <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      r_st_q <= r_st_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
endmodule
